// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Optional feature macro: RF_ARB_STATS_EN (contention counter).
package rf_pkg;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  localparam logic [AW-1:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_req_t;

  function automatic logic is_xzr(input logic [AW-1:0] a);
    return a == XZR_IDX;
  endfunction

endpackage

// File: rtl/rf_wr_arb_rr_arb2.sv
// Two-way round-robin grant logic with a 1-bit priority pointer.
// ptr_q = 0 favours requester 0, ptr_q = 1 favours requester 1.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant terms are mutually exclusive; no grant while in reset.
  always_comb begin
    gnt_o    = '0;
    gnt_o[0] = rst_n & valid_i[0]
             & (~valid_i[1] | ~ptr_q);
    gnt_o[1] = rst_n & valid_i[1]
             & (~valid_i[0] | ptr_q);
  end

  // After a grant, favour the requester that lost.
  always_comb begin
    ptr_d = ptr_q;
    unique case (1'b1)
      gnt_o[0]: ptr_d = 1'b1;
      gnt_o[1]: ptr_d = 1'b0;
      default:  ptr_d = ptr_q;
    endcase
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wr_arb.sv
// Register-file write-back arbiter: ALU (req0) vs load (req1).
// Define RF_ARB_STATS_EN to add the stall_cnt contention counter.
module rf_wr_arb
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            Reset,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_reg,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_reg,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic            RegWrite,
  output logic [AW-1:0]   WriteReg,
  output logic [XLEN-1:0] WriteData
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  wr_req_t r0;
  wr_req_t r1;
  logic [1:0] gnt;

  logic            we_d, we_q;
  logic [AW-1:0]   wreg_d, wreg_q;
  logic [XLEN-1:0] wdat_d, wdat_q;

  assign r0 = '{valid: req0_valid,
                rd:    req0_reg,
                data:  req0_data};
  assign r1 = '{valid: req1_valid,
                rd:    req1_reg,
                data:  req1_data};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (Reset),
    .valid_i ({r1.valid, r0.valid}),
    .gnt_o   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Select the granted request; XZR transfers are accepted but dropped.
  always_comb begin
    wreg_d = gnt[1] ? r1.rd   : r0.rd;
    wdat_d = gnt[1] ? r1.data : r0.data;
    we_d   = (|gnt) & ~is_xzr(wreg_d);
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      we_q   <= 1'b0;
      wreg_q <= '0;
      wdat_q <= '0;
    end else begin
      we_q <= we_d;
      if (we_d) begin
        wreg_q <= wreg_d;
        wdat_q <= wdat_d;
      end
    end
  end

  assign RegWrite  = we_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdat_q;

`ifdef RF_ARB_STATS_EN
  logic [15:0] stall_q;

  // Count cycles where both requesters contend, saturating.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      stall_q <= '0;
    end else if (r0.valid && r1.valid
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rf_wr_arb.sv
// Scoreboard bench for rf_wr_arb: random and directed write-back traffic.
// Builds with or without RF_ARB_STATS_EN.
module tb_rf_wr_arb;

  logic        clk = 1'b0;
  logic        Reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_reg, req1_reg;
  logic [63:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
`ifdef RF_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  rf_wr_arb dut (
    .clk        (clk),
    .Reset      (Reset),
    .req0_valid (req0_valid),
    .req0_reg   (req0_reg),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_reg   (req1_reg),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData)
`ifdef RF_ARB_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] xrf [32];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          favour = 0;
  int          exp_stall = 0;
  bit          hs0, hs1;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: predicts grants and expected writes.
  always @(negedge clk) begin
    bit e0, e1;
    if (!Reset) begin
      favour = 0;
      exp_stall = 0;
      sb.delete();
      checks++;
      if (req0_ready || req1_ready) begin
        errors++;
        $display("FAIL rst_ready got %b%b want 00",
                 req1_ready, req0_ready);
      end
    end else begin
      e0 = req0_valid && (!req1_valid || favour == 0);
      e1 = req1_valid && !e0;
      checks++;
      if (req0_ready !== e0 || req1_ready !== e1) begin
        errors++;
        $display("FAIL ready t=%0t got %b%b want %b%b",
                 $time, req1_ready, req0_ready, e1, e0);
      end
      if (e0 && req0_reg != 5'd31)
        sb.push_back('{req0_reg, req0_data, cyc + 1});
      if (e1 && req1_reg != 5'd31)
        sb.push_back('{req1_reg, req1_data, cyc + 1});
      if (e0) favour = 1;
      else if (e1) favour = 0;
`ifdef RF_ARB_STATS_EN
      checks++;
      if (int'(stall_cnt) != exp_stall) begin
        errors++;
        $display("FAIL stall_cnt got %0d want %0d",
                 stall_cnt, exp_stall);
      end
      if (req0_valid && req1_valid && exp_stall < 65535)
        exp_stall++;
`endif
    end
  end

  // Monitor: pops the scoreboard on every RegWrite pulse.
  always @(negedge clk) begin
    if (Reset && sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_write got none want x%0d=%h",
               sb[0].rd, sb[0].data);
      void'(sb.pop_front());
    end
    if (RegWrite === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_write got x%0d=%h want none",
                 WriteReg, WriteData);
      end else if (sb[0].due != cyc || sb[0].rd != WriteReg
                   || sb[0].data != WriteData) begin
        errors++;
        $display("FAIL write got x%0d=%h want x%0d=%h",
                 WriteReg, WriteData, sb[0].rd, sb[0].data);
        void'(sb.pop_front());
      end else begin
        void'(sb.pop_front());
      end
      xrf[WriteReg] = WriteData;
    end
  end

  // One cycle: record handshakes, then step past the edge.
  task automatic step();
    @(negedge clk);
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0_valid = 0;
    req1_valid = 0;
    repeat (n) step();
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic do_reset();
    Reset = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 Reset = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    Reset = 0;
    req0_valid = 1; req0_reg = 5'd9;
    req0_data = 64'h1;
    req1_valid = 1; req1_reg = 5'd8;
    req1_data = 64'h2;
    foreach (xrf[i]) xrf[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_wreg", 64'(WriteReg), 64'd0);
    chk("rst_wdata", WriteData, 64'd0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk);
    #1 Reset = 1;

    // single requester 0
    req0_valid = 1; req0_reg = 5'd3;
    req0_data = 64'd4;
    #1 chk("r0_ready", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 0;
    chk("r0_we", 64'(RegWrite), 64'd1);
    chk("r0_wreg", 64'(WriteReg), 64'd3);
    chk("r0_wdata", WriteData, 64'd4);
    idle(2);
    chk("idle_we", 64'(RegWrite), 64'd0);
    chk("hold_wreg", 64'(WriteReg), 64'd3);

    // both valid from reset: 0,1,0,1
    do_reset();
    req0_valid = 1; req0_reg = 5'd1;
    req0_data = 64'hA;
    req1_valid = 1; req1_reg = 5'd2;
    req1_data = 64'hB;
    repeat (4) step();
    idle(2);

    // XZR from requester 1
    req1_valid = 1; req1_reg = 5'd31;
    req1_data = 64'hFF;
    #1 chk("xzr_ready", 64'(req1_ready), 64'd1);
    step();
    req1_valid = 0;
    chk("xzr_we", 64'(RegWrite), 64'd0);
    idle(2);

    // same destination, pointer=0
    do_reset();
    req0_valid = 1; req0_reg = 5'd5;
    req0_data = 64'd1;
    req1_valid = 1; req1_reg = 5'd5;
    req1_data = 64'd2;
    step();
    req0_valid = 0;
    step();
    req1_valid = 0;
    idle(2);
    chk("x5_readback", xrf[5], 64'd2);

    // reset mid-cycle right after a grant
    req0_valid = 1; req0_reg = 5'd7;
    req0_data = 64'h77;
    step();
    chk("pre_rst_we", 64'(RegWrite), 64'd1);
    #2 Reset = 0;
    req0_valid = 0;
    sb.delete();
    #1 chk("async_we", 64'(RegWrite), 64'd0);
    chk("async_wdata", WriteData, 64'd0);
    repeat (2) @(posedge clk);
    #1 Reset = 1;
    idle(3);

    // random traffic, requests held until accepted
    hs0 = 0; hs1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!req0_valid || hs0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_reg = ($urandom_range(0, 7) == 0)
                 ? 5'd31 : 5'($urandom_range(0, 31));
        req0_data = {$urandom, $urandom};
      end
      if (!req1_valid || hs1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_reg = ($urandom_range(0, 7) == 0)
                 ? 5'd31 : 5'($urandom_range(0, 31));
        req1_data = {$urandom, $urandom};
      end
      step();
    end
    idle(3);

`ifdef RF_ARB_STATS_EN
    do_reset();
    req0_valid = 1; req0_reg = 5'd4;
    req0_data = 64'h40;
    req1_valid = 1; req1_reg = 5'd6;
    req1_data = 64'h60;
    repeat (70000) step();
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
    idle(2);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
